// File: rtl/retire_mon_pkg.sv
// Shared types and helpers for the writeback retire monitor: FSM state and
// halt-cause encodings, counter width, and a saturating increment.
package retire_mon_pkg;

    localparam int CNT_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mon_state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'd0,
        CAUSE_ADDR = 2'd1,
        CAUSE_SPIN = 2'd2,
        CAUSE_WDOG = 2'd3
    } halt_cause_t;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/retire_trace_buf.sv
// Ring buffer of the most recently retired PCs. Read index 0 is the newest
// entry; slots never written since reset read back as zero. The write pointer
// wraps naturally because DEPTH is a power of two.
module retire_trace_buf #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     wr_en,
    input  logic [31:0]              wr_pc,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [31:0]              rd_pc
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   ring [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rd_slot;

    // Store each retired PC at the write pointer and advance it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                ring[i] <= '0;
            end
        end else if (wr_en) begin
            ring[wptr] <= wr_pc;
            wptr       <= wptr + 1'b1;
        end
    end

    // Newest entry sits one slot behind the write pointer.
    always_comb begin
        rd_slot = wptr - AW'(1) - rd_idx;
    end

    assign rd_pc = ring[rd_slot];

endmodule

// File: rtl/wb_retire_monitor.sv
// End-of-run monitor behind the writeback stage. Counts RUN cycles and
// retires, remembers the last retired PC/instruction, and stops the run on a
// halt-address retire, a PC spinning on itself, or a retire watchdog timeout.
// Optional feature macro: RETIRE_TRACE_EN adds a ring buffer of recent PCs
// readable through trace_rd_idx/trace_rd_pc; without it trace_rd_pc reads 0.
module wb_retire_monitor
    import retire_mon_pkg::*;
#(
    parameter logic [31:0] HALT_PC     = 32'h0000_00ff,
    parameter int unsigned SPIN_LIMIT  = 8,
    parameter int unsigned WDOG_CYCLES = 1024,
    parameter int unsigned TRACE_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           retire_valid,
    input  logic [31:0]                    pcW,
    input  logic [31:0]                    instrW,
    output logic                           halted,
    output logic [1:0]                     halt_cause,
    output logic [31:0]                    cycle_cnt,
    output logic [31:0]                    retire_cnt,
    output logic [31:0]                    last_pc,
    output logic [31:0]                    last_instr,
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_rd_idx,
    output logic [31:0]                    trace_rd_pc
);

    mon_state_t        state;
    halt_cause_t       cause;
    logic [CNT_W-1:0]  spin_cnt;
    logic [CNT_W-1:0]  idle_cnt;

    logic              active;
    logic              retire;
    logic [CNT_W-1:0]  spin_next;
    logic              addr_hit;
    logic              spin_hit;
    logic              wdog_hit;
    halt_cause_t       cause_next;

    // Halt detection. The watchdog fires on the cycle after the idle count has
    // reached its limit, i.e. once WDOG_CYCLES full idle RUN cycles have passed.
    always_comb begin
        active    = (state != ST_DONE);
        retire    = retire_valid && active;
        spin_next = (pcW == last_pc) ? sat_inc(spin_cnt) : CNT_W'(1);
        addr_hit  = retire && (pcW == HALT_PC);
        spin_hit  = retire && (SPIN_LIMIT != 0) && (spin_next == CNT_W'(SPIN_LIMIT));
        wdog_hit  = (state == ST_RUN) && (WDOG_CYCLES != 0) &&
                    (idle_cnt == CNT_W'(WDOG_CYCLES));
        if (addr_hit) begin
            cause_next = CAUSE_ADDR;
        end else if (spin_hit) begin
            cause_next = CAUSE_SPIN;
        end else if (wdog_hit) begin
            cause_next = CAUSE_WDOG;
        end else begin
            cause_next = CAUSE_NONE;
        end
    end

    // FSM, counters and last-retire capture; everything freezes in DONE.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            cause      <= CAUSE_NONE;
            halted     <= 1'b0;
            cycle_cnt  <= '0;
            retire_cnt <= '0;
            last_pc    <= '0;
            last_instr <= '0;
            spin_cnt   <= '0;
            idle_cnt   <= '0;
        end else if (active) begin
            if (state == ST_RUN) begin
                cycle_cnt <= sat_inc(cycle_cnt);
            end
            if (retire) begin
                retire_cnt <= sat_inc(retire_cnt);
                last_pc    <= pcW;
                last_instr <= instrW;
                spin_cnt   <= spin_next;
                idle_cnt   <= '0;
            end else if (state == ST_RUN) begin
                idle_cnt <= sat_inc(idle_cnt);
            end
            if (cause_next != CAUSE_NONE) begin
                state  <= ST_DONE;
                cause  <= cause_next;
                halted <= 1'b1;
            end else if (retire) begin
                state <= ST_RUN;
            end
        end
    end

    assign halt_cause = cause;

`ifdef RETIRE_TRACE_EN
    retire_trace_buf #(
        .DEPTH (TRACE_DEPTH)
    ) u_trace (
        .clk    (clk),
        .rstn   (rstn),
        .wr_en  (retire),
        .wr_pc  (pcW),
        .rd_idx (trace_rd_idx),
        .rd_pc  (trace_rd_pc)
    );
`else
    logic unused_trace_idx;
    assign unused_trace_idx = ^trace_rd_idx;
    assign trace_rd_pc      = 32'h0;
`endif

endmodule

// File: tb/tb_wb_retire_monitor.sv
// Bench for wb_retire_monitor: directed scenarios with literal expectations
// plus randomized runs, all compared every cycle against a behavioural model.
module tb_wb_retire_monitor;

    localparam logic [31:0] HALT   = 32'h0000_00ff;
    localparam int          SPIN   = 8;
    localparam int          WDOG   = 16;
    localparam int          TDEPTH = 8;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        retire_valid = 1'b0;
    logic [31:0] pcW = '0;
    logic [31:0] instrW = '0;
    logic [2:0]  trace_rd_idx = '0;
    logic        halted;
    logic [1:0]  halt_cause;
    logic [31:0] cycle_cnt, retire_cnt, last_pc, last_instr, trace_rd_pc;

    int checks = 0;
    int failures = 0;

    wb_retire_monitor #(
        .HALT_PC     (HALT),
        .SPIN_LIMIT  (SPIN),
        .WDOG_CYCLES (WDOG),
        .TRACE_DEPTH (TDEPTH)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .retire_valid (retire_valid),
        .pcW          (pcW),
        .instrW       (instrW),
        .halted       (halted),
        .halt_cause   (halt_cause),
        .cycle_cnt    (cycle_cnt),
        .retire_cnt   (retire_cnt),
        .last_pc      (last_pc),
        .last_instr   (last_instr),
        .trace_rd_idx (trace_rd_idx),
        .trace_rd_pc  (trace_rd_pc)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit          m_started, m_done;
    int unsigned m_cause, m_cycles, m_retires, m_spin, m_idle;
    logic [31:0] m_last_pc, m_last_instr;
    logic [31:0] m_trace[$];

    initial forever begin
        @(posedge clk or negedge rstn);
        if (!rstn) begin
            m_started = 0; m_done = 0; m_cause = 0; m_cycles = 0; m_retires = 0;
            m_spin = 0; m_idle = 0; m_last_pc = '0; m_last_instr = '0;
            m_trace.delete();
        end else if (!m_done) begin
            int unsigned c, s;
            c = 0;
            s = m_spin;
            if (retire_valid) begin
                s = (pcW == m_last_pc) ? m_spin + 1 : 1;
                if (pcW == HALT) c = 1;
                else if (s == SPIN) c = 2;
            end
            // the run has already sat through WDOG idle RUN cycles
            if (c == 0 && m_started && m_idle == WDOG) c = 3;
            if (m_started) m_cycles++;
            if (retire_valid) begin
                m_retires++;
                m_last_pc = pcW;
                m_last_instr = instrW;
                m_spin = s;
                m_idle = 0;
                m_trace.push_back(pcW);
            end else if (m_started) begin
                m_idle++;
            end
            if (c != 0) begin
                m_done = 1;
                m_cause = c;
            end else if (retire_valid) begin
                m_started = 1;
            end
        end
    end

    function automatic logic [31:0] exp_trace(input int idx);
`ifdef RETIRE_TRACE_EN
        if (idx < m_trace.size()) return m_trace[m_trace.size() - 1 - idx];
        return 32'h0;
`else
        return 32'h0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // every-cycle comparison against the model, away from the rising edge
    initial forever begin
        @(negedge clk);
        chk("halted",     {31'd0, halted},     {31'd0, m_done});
        chk("halt_cause", {30'd0, halt_cause}, m_cause);
        chk("cycle_cnt",  cycle_cnt,  m_cycles);
        chk("retire_cnt", retire_cnt, m_retires);
        chk("last_pc",    last_pc,    m_last_pc);
        chk("last_instr", last_instr, m_last_instr);
        chk("trace_rd_pc", trace_rd_pc, exp_trace(int'(trace_rd_idx)));
    end

    // ---------------- stimulus helpers ----------------
    // Called at posedge+2; drives inputs, lets one edge sample them, returns at posedge+2.
    task automatic cyc(input logic v, input logic [31:0] pc);
        retire_valid = v;
        pcW = pc;
        instrW = $urandom;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        retire_valid = 0;
        rstn = 0;
        repeat (2) @(posedge clk);
        #2;
        rstn = 1;
    endtask

    initial begin
        logic [31:0] held_cycles;
        logic [31:0] drv_pc;
        logic [31:0] pool [6];
        pool = '{32'h40, 32'h44, 32'h48, 32'h100, 32'h104, 32'h0};

        // reset state
        do_reset();
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_retire", retire_cnt, 32'd0);
        chk("rst_cycle",  cycle_cnt,  32'd0);

        // 1: sequential PCs up to the halt address
        for (int i = 0; i < 64; i++) cyc(1, 32'(i * 4));
        cyc(1, HALT);
        chk("t1_halted", {31'd0, halted}, 32'd1);
        chk("t1_cause",  {30'd0, halt_cause}, 32'd1);
        chk("t1_last_pc", last_pc, 32'hff);
        chk("t1_retire", retire_cnt, 32'd65);
        chk("t1_cycle",  cycle_cnt,  32'd64);
        held_cycles = cycle_cnt;
        for (int i = 0; i < 20; i++) cyc(1'($urandom_range(0, 1)), $urandom);
        chk("t1_hold_retire", retire_cnt, 32'd65);
        chk("t1_hold_cycle",  cycle_cnt,  held_cycles);
        chk("t1_hold_pc",     last_pc,    32'hff);

        // 2: spin on one PC
        do_reset();
        for (int i = 0; i < 7; i++) cyc(1, 32'h40);
        chk("t2_not_yet", {31'd0, halted}, 32'd0);
        cyc(1, 32'h40);
        chk("t2_halted", {31'd0, halted}, 32'd1);
        chk("t2_cause",  {30'd0, halt_cause}, 32'd2);
        chk("t2_retire", retire_cnt, 32'd8);

        // 3: watchdog after one retire
        do_reset();
        cyc(1, 32'h100);
        for (int i = 0; i < 16; i++) cyc(0, 32'h0);
        chk("t3_not_yet", {31'd0, halted}, 32'd0);
        chk("t3_cycle16", cycle_cnt, 32'd16);
        cyc(0, 32'h0);
        chk("t3_cause", {30'd0, halt_cause}, 32'd3);
        chk("t3_cycle", cycle_cnt, 32'd17);

        // 4a: halt address beats a simultaneous watchdog
        do_reset();
        cyc(1, 32'h200);
        for (int i = 0; i < 16; i++) cyc(0, 32'h0);
        cyc(1, HALT);
        chk("t4a_cause",  {30'd0, halt_cause}, 32'd1);
        chk("t4a_retire", retire_cnt, 32'd2);
        chk("t4a_cycle",  cycle_cnt,  32'd17);

        // 4b: spin beats a simultaneous watchdog
        do_reset();
        for (int i = 0; i < 7; i++) cyc(1, 32'h40);
        for (int i = 0; i < 16; i++) cyc(0, 32'h0);
        cyc(1, 32'h40);
        chk("t4b_cause",  {30'd0, halt_cause}, 32'd2);
        chk("t4b_retire", retire_cnt, 32'd8);
        chk("t4b_cycle",  cycle_cnt,  32'd23);

        // 5: asynchronous reset mid-run
        do_reset();
        for (int i = 0; i < 30; i++) cyc(1, 32'h1000 + 32'(i * 4));
        chk("t5_retire30", retire_cnt, 32'd30);
        #2;
        rstn = 0;
        #1;
        chk("t5_async_retire", retire_cnt, 32'd0);
        chk("t5_async_cycle",  cycle_cnt,  32'd0);
        chk("t5_async_pc",     last_pc,    32'd0);
        chk("t5_async_instr",  last_instr, 32'd0);
        chk("t5_async_halted", {30'd0, halted, 1'b0} | {30'd0, halt_cause}, 32'd0);
        @(posedge clk);
        #2;
        rstn = 1;
        for (int i = 0; i < 3; i++) cyc(1, 32'h500 + 32'(i * 4));
        chk("t5_restart_retire", retire_cnt, 32'd3);
        chk("t5_restart_cycle",  cycle_cnt,  32'd2);

        // 6: trace readback
        do_reset();
        for (int i = 0; i < 10; i++) cyc(1, 32'h10 + 32'(i * 4));
        trace_rd_idx = 3'd0;
        #1;
`ifdef RETIRE_TRACE_EN
        chk("t6_idx0", trace_rd_pc, 32'h34);
`else
        chk("t6_idx0", trace_rd_pc, 32'h0);
`endif
        trace_rd_idx = 3'd7;
        #1;
`ifdef RETIRE_TRACE_EN
        chk("t6_idx7", trace_rd_pc, 32'h18);
`else
        chk("t6_idx7", trace_rd_pc, 32'h0);
`endif
        @(posedge clk);
        #2;

        // randomized runs, odd runs with sparse retires to reach the watchdog
        for (int run = 0; run < 8; run++) begin
            int tail;
            do_reset();
            drv_pc = pool[$urandom_range(0, 5)];
            tail = -1;
            for (int c = 0; c < 600 && tail != 0; c++) begin
                logic v;
                int   r;
                if (run % 2 == 1) v = ($urandom_range(0, 9) == 0);
                else              v = ($urandom_range(0, 3) != 0);
                r = $urandom_range(0, 99);
                if (r >= 45 && r < 97) drv_pc = pool[$urandom_range(0, 5)];
                else if (r >= 97)      drv_pc = HALT;
                trace_rd_idx = 3'($urandom_range(0, 7));
                cyc(v, drv_pc);
                if (tail > 0) tail--;
                else if (tail < 0 && m_done) tail = 5;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
